uart_byte_receiver: RTL and testbench

//  Serial-to-parallel UART receiver, 8N1 (8E1 optional), LSB first, idle-high line.

---
 rtl/uart_byte_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// 16x-oversampling UART receiver (8N1, LSB first) with a one-entry valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module uart_byte_receiver #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RxWire,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       FrameError,
    output logic       ParityError,
    output logic       Overrun,
    output logic       Busy
);

    localparam int OVERSAMPLE   = 16;
    localparam int TICK_DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state, state_next;
    logic              rx_meta, rx_s;
    logic              armed, armed_next;
    logic [TICK_W-1:0] div_cnt;
    logic              tick;
    logic [3:0]        os_cnt, os_next;
    logic [2:0]        bit_cnt, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              par_bad, par_bad_next;
    logic              commit, frame_err, parity_err;

    // Presetting to 1 makes reset look like an idle line, so no phantom start bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxWire;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != S_IDLE) && (div_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            armed     <= 1'b1;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bad   <= 1'b0;
        end else begin
            state     <= state_next;
            armed     <= armed_next;
            os_cnt    <= os_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            par_bad   <= par_bad_next;
        end
    end

    always_comb begin
        state_next   = state;
        os_next      = os_cnt;
        bit_next     = bit_cnt;
        shift_next   = shift_reg;
        par_bad_next = par_bad;
        commit       = 1'b0;
        frame_err    = 1'b0;
        parity_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    state_next   = S_START;
                    os_next      = '0;
                    bit_next     = '0;
                    par_bad_next = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (os_cnt == 4'd7) begin
                        os_next    = '0;
                        state_next = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        os_next = os_cnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        shift_next = {rx_s, shift_reg[7:1]};
                        bit_next   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        if (rx_s != ^shift_reg) begin
                            parity_err   = 1'b1;
                            par_bad_next = 1'b1;
                        end
                        state_next = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    os_next = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        // Leave at mid stop bit so a start edge right after it is caught.
                        state_next = S_IDLE;
                        if (!rx_s) begin
                            frame_err = 1'b1;
                        end else if (!par_bad) begin
                            commit = 1'b1;
                        end
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // After a framing error the line may be held low (break); re-arm only once it idles high.
    always_comb begin
        armed_next = armed;
        if (frame_err) begin
            armed_next = 1'b0;
        end else if (rx_s) begin
            armed_next = 1'b1;
        end
    end

    // Handshake: a byte transfers on any cycle with RxValid && RxReady; RxValid then drops
    // unless a new byte commits in that same cycle. A commit into a full, unaccepted
    // register is dropped and flagged with Overrun.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RxData      <= 8'h00;
            RxValid     <= 1'b0;
            FrameError  <= 1'b0;
            ParityError <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            FrameError  <= frame_err;
            ParityError <= parity_err;
            Overrun     <= 1'b0;
            if (commit) begin
                if (!RxValid || RxReady) begin
                    RxData  <= shift_reg;
                    RxValid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (RxReady) begin
                RxValid <= 1'b0;
            end
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Randomized scoreboard bench for uart_byte_receiver at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_byte_receiver;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [1:0] EV_DATA = 2'd0;
  localparam logic [1:0] EV_FE   = 2'd1;
  localparam logic [1:0] EV_OV   = 2'd2;
  localparam logic [1:0] EV_PE   = 2'd3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       RxWire = 1'b1;
  logic       RxReady = 1'b1;
  logic [7:0] RxData;
  logic       RxValid, FrameError, ParityError, Overrun, Busy;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  uart_byte_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .Clk(Clk), .Reset(Reset), .RxWire(RxWire), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .FrameError(FrameError), .ParityError(ParityError),
    .Overrun(Overrun), .Busy(Busy)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge Clk);
    #1 RxReady = r;
  endtask

  task automatic drive_bit(input logic b);
    RxWire = b;
    repeat (BIT_CLKS) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_ok ? ^d : ~^d);
    drive_bit(stop_bit);
    RxWire = 1'b1;
  endtask

  // reference model: what a consumer that keeps up should observe from one frame
  task automatic expect_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    if (PAR_EN && !par_ok) exp_q.push_back({EV_PE, 8'h00});
    if (!stop_bit) exp_q.push_back({EV_FE, 8'h00});
    else if (!PAR_EN || par_ok) exp_q.push_back({EV_DATA, d});
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_event(input logic [1:0] kind, input logic [7:0] d, input string name);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data=%02h with nothing expected", name, d);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, d}) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%02h, required kind=%0d data=%02h",
                 name, kind, d, e[9:8], e[7:0]);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (FrameError)        check_event(EV_FE, 8'h00, "frame_error");
      if (ParityError)       check_event(EV_PE, 8'h00, "parity_error");
      if (Overrun)           check_event(EV_OV, 8'h00, "overrun");
      if (RxValid && RxReady) check_event(EV_DATA, RxData, "rx_data");
    end
  end

  // stimulus
  initial begin
    int cnt;
    logic [7:0] d;
    logic stop_bit, par_ok;

    idle(5);
    check("reset_rxvalid", RxValid, 0);
    check("reset_rxdata", RxData, 8'h00);
    check("reset_busy", Busy, 0);
    check("reset_flags", {FrameError, ParityError, Overrun}, 3'b000);
    Reset = 1'b0;
    idle(5);

    // single frame, latency and one-cycle valid
    expect_frame(8'hA5, 1'b1, 1'b1);
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        cnt = 0;
        while (!RxValid && cnt < 400) begin
          @(negedge Clk);
          cnt++;
        end
        check("latency_window", (cnt >= 150 && cnt <= 160), 1);
        check("first_rxdata", RxData, 8'hA5);
        @(negedge Clk);
        check("valid_one_cycle", RxValid, 0);
      end
    join
    idle(20);

    // false start
    RxWire = 1'b0;
    idle(4);
    check("false_start_busy_set", Busy, 1);
    RxWire = 1'b1;
    cnt = 0;
    while (Busy && cnt < 40) begin
      @(negedge Clk);
      cnt++;
    end
    check("false_start_busy_clear", Busy, 0);
    idle(20);

    // bad stop bit
    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(20);
    check("rxdata_kept_after_fe", RxData, 8'hA5);
    check("rxvalid_after_fe", RxValid, 0);

    // randomized stream with a consumer that always accepts
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 5) != 0);
      par_ok = ($urandom_range(0, 5) != 0);
      expect_frame(d, stop_bit, par_ok);
      send_frame(d, stop_bit, par_ok);
      idle(stop_bit ? $urandom_range(0, 40) : $urandom_range(16, 40));
    end
    idle(20);

    // break: line held low for many bit times gives exactly one framing error
    exp_q.push_back({EV_FE, 8'h00});
    RxWire = 1'b0;
    idle(BIT_CLKS * 30);
    RxWire = 1'b1;
    idle(40);
    check("break_busy_clear", Busy, 0);
    expect_frame(8'h96, 1'b1, 1'b1);
    send_frame(8'h96, 1'b1, 1'b1);
    idle(20);

    // overrun with a stalled consumer
    set_ready(1'b0);
    exp_q.push_back({EV_OV, 8'h00});
    exp_q.push_back({EV_DATA, 8'h11});
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(5);
    check("overrun_valid_held", RxValid, 1);
    check("overrun_old_byte_kept", RxData, 8'h11);
    set_ready(1'b1);
    idle(2);
    check("overrun_valid_cleared", RxValid, 0);
    check("overrun_rxdata_unchanged", RxData, 8'h11);

    // reset during data bit 3 while a byte is held
    set_ready(1'b0);
    send_frame(8'h33, 1'b1, 1'b1);
    idle(5);
    check("held_before_reset", RxValid, 1);
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    RxWire = d[3];
    idle(BIT_CLKS / 2);
    Reset = 1'b1;
    #1;
    check("midframe_reset_rxvalid", RxValid, 0);
    check("midframe_reset_rxdata", RxData, 8'h00);
    check("midframe_reset_busy", Busy, 0);
    exp_q.delete();
    RxWire = 1'b1;
    idle(3);
    Reset = 1'b0;
    set_ready(1'b1);
    idle(5);
    expect_frame(8'h5A, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(20);

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("parity_bad_no_valid", RxValid, 0);
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
`endif

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge Clk);
      cnt++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
